// File: rtl/memory_bus_arbiter.sv
// Two-core arbiter in front of a single main memory with a fixed access latency.
// Ties go to the core that was not granted last, so continuous contention alternates.
module memory_bus_arbiter #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned DEPTH       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd_1,
    input  logic        mem_rd_2,
    input  logic        main_mem_wr_1,
    input  logic        main_mem_wr_2,
    input  logic [4:0]  addr_mem_1,
    input  logic [4:0]  addr_mem_2,
    input  logic [31:0] wr_data_1,
    input  logic [31:0] wr_data_2,
    output logic [31:0] mem_data_out_1,
    output logic [31:0] mem_data_out_2,
    output logic        stall_mem_1,
    output logic        stall_mem_2,
    output logic        done_1,
    output logic        done_2,
    output logic        busy
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_LOAD = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      r_state, w_state_next;
    logic [3:0]  r_cnt;
    logic        r_last_grant;  // 0: core 1, 1: core 2
    logic        r_grant;
    logic        r_is_wr;
    logic [4:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata_1;
    logic [31:0] r_rdata_2;
    logic [31:0] r_mem [DEPTH];

    logic          w_req_1;
    logic          w_req_2;
    logic          w_start;
    logic          w_grant_sel;
    logic          w_access;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word;

    assign w_req_1   = mem_rd_1 | main_mem_wr_1;
    assign w_req_2   = mem_rd_2 | main_mem_wr_2;
    assign w_idx     = AW'(32'(r_addr) % DEPTH);
    assign w_rd_word = r_mem[w_idx];

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_grant_sel  = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req_1 || w_req_2) begin
                    w_start      = 1'b1;
                    w_state_next = StAccess;
                    if (w_req_1 && w_req_2) begin
                        w_grant_sel = ~r_last_grant;
                    end else begin
                        w_grant_sel = w_req_2;
                    end
                end
            end
            StAccess: begin
                if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_is_wr      <= 1'b0;
            r_addr       <= 5'd0;
            r_wdata      <= 32'h0;
            r_rdata_1    <= 32'h0;
            r_rdata_2    <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_grant <= w_grant_sel;
                r_is_wr <= w_grant_sel ? main_mem_wr_2 : main_mem_wr_1;
                r_addr  <= w_grant_sel ? addr_mem_2 : addr_mem_1;
                r_wdata <= w_grant_sel ? wr_data_2 : wr_data_1;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == StAccess && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !r_is_wr) begin
                if (r_grant) begin
                    r_rdata_2 <= w_rd_word;
                end else begin
                    r_rdata_1 <= w_rd_word;
                end
            end
            if (r_state == StDone) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Storage is deliberately not reset; an aborted transfer never reaches w_access.
    always_ff @(posedge clk) begin
        if (w_access && r_is_wr) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign done_1         = (r_state == StDone) && !r_grant;
    assign done_2         = (r_state == StDone) && r_grant;
    assign busy           = (r_state != StIdle);
    assign stall_mem_1    = w_req_1 & ~done_1;
    assign stall_mem_2    = w_req_2 & ~done_2;
    assign mem_data_out_1 = r_rdata_1;
    assign mem_data_out_2 = r_rdata_2;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: vector table, directed corner cases,
// and randomized two-core traffic against a transaction-level schedule model.
module tb_memory_bus_arbiter;

    localparam int unsigned LAT = 2;
    localparam int unsigned DEP = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd_1, mem_rd_2, main_mem_wr_1, main_mem_wr_2;
    logic [4:0]  addr_mem_1, addr_mem_2;
    logic [31:0] wr_data_1, wr_data_2;
    logic [31:0] mem_data_out_1, mem_data_out_2;
    logic        stall_mem_1, stall_mem_2, done_1, done_2, busy;

    typedef struct {
        int          core;
        logic        rd;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [10];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_out [3];
    logic [31:0] mdl_mem [DEP];

    int          t1, t2, st2, nd, both, nd1;
    int          order [4];
    int          m_cur, m_last, m_start, m_done, op;
    logic        m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        e_done [3];
    logic        e_busy;
    logic        a_act [3];
    logic        a_drop [3];
    logic        a_rd [3];
    logic        a_wr [3];
    logic [4:0]  a_addr [3];
    logic [31:0] a_data [3];

    memory_bus_arbiter #(
        .MEM_LATENCY(LAT),
        .DEPTH      (DEP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_rd_1      (mem_rd_1),
        .mem_rd_2      (mem_rd_2),
        .main_mem_wr_1 (main_mem_wr_1),
        .main_mem_wr_2 (main_mem_wr_2),
        .addr_mem_1    (addr_mem_1),
        .addr_mem_2    (addr_mem_2),
        .wr_data_1     (wr_data_1),
        .wr_data_2     (wr_data_2),
        .mem_data_out_1(mem_data_out_1),
        .mem_data_out_2(mem_data_out_2),
        .stall_mem_1   (stall_mem_1),
        .stall_mem_2   (stall_mem_2),
        .done_1        (done_1),
        .done_2        (done_2),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic set_core(input int core, input logic rd, input logic wr,
                            input logic [4:0] addr, input logic [31:0] data);
        if (core == 1) begin
            mem_rd_1 = rd; main_mem_wr_1 = wr; addr_mem_1 = addr; wr_data_1 = data;
        end else begin
            mem_rd_2 = rd; main_mem_wr_2 = wr; addr_mem_2 = addr; wr_data_2 = data;
        end
    endtask

    task automatic idle_pins();
        set_core(1, 1'b0, 1'b0, 5'd0, 32'h0);
        set_core(2, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic pulse_reset();
        idle_pins();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_out[1] = 32'h0;
        exp_out[2] = 32'h0;
    endtask

    // One isolated transfer; entered and left just after a rising edge.
    task automatic xfer(input int core, input logic rd, input logic wr, input logic [4:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd, input string tag);
        int   k;
        int   stalls;
        logic seen;
        logic d;
        logic s;
        k = 0; stalls = 0; seen = 1'b0;
        set_core(core, rd, wr, addr, data);
        while (!seen && k < 20) begin
            @(negedge clk);
            d = (core == 1) ? done_1 : done_2;
            s = (core == 1) ? stall_mem_1 : stall_mem_2;
            if (d) begin
                seen = 1'b1;
                chk({tag, " latency"}, k, LAT + 1);
                chk1({tag, " stall in done cycle"}, s, 1'b0);
                chk({tag, " stall cycles"}, stalls, LAT + 1);
                if (!wr) exp_out[core] = exp_rd;
                chk({tag, " out1"}, mem_data_out_1, exp_out[1]);
                chk({tag, " out2"}, mem_data_out_2, exp_out[2]);
            end else if (s) begin
                stalls++;
            end
            @(posedge clk); #1;
            k++;
        end
        chk1({tag, " done seen"}, seen, 1'b1);
        set_core(core, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        vecs[0] = '{1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{2, 1'b1, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
        vecs[2] = '{2, 1'b1, 1'b1, 5'd3,  32'hA5A5A5A5, 32'h0};
        vecs[3] = '{1, 1'b1, 1'b0, 5'd3,  32'h0,        32'hA5A5A5A5};
        vecs[4] = '{1, 1'b0, 1'b1, 5'd9,  32'h0BADF00D, 32'h0};
        vecs[5] = '{2, 1'b1, 1'b0, 5'd9,  32'h0,        32'h0BADF00D};
        vecs[6] = '{2, 1'b0, 1'b1, 5'd31, 32'hFFFF0001, 32'h0};
        vecs[7] = '{1, 1'b1, 1'b0, 5'd31, 32'h0,        32'hFFFF0001};
        vecs[8] = '{1, 1'b0, 1'b1, 5'd0,  32'h00000042, 32'h0};
        vecs[9] = '{2, 1'b1, 1'b0, 5'd0,  32'h0,        32'h00000042};

        // Reset state
        idle_pins();
        reset = 1'b0;
        exp_out[1] = 32'h0;
        exp_out[2] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset busy", busy, 1'b0);
        chk1("reset done_1", done_1, 1'b0);
        chk1("reset done_2", done_2, 1'b0);
        chk1("reset stall_1", stall_mem_1, 1'b0);
        chk1("reset stall_2", stall_mem_2, 1'b0);
        chk("reset out1", mem_data_out_1, 32'h0);
        chk("reset out2", mem_data_out_2, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].core, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                 vecs[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Tie straight after reset: core 1 first, core 2 waits a full transfer
        pulse_reset();
        set_core(1, 1'b1, 1'b0, 5'd5, 32'h0);
        set_core(2, 1'b1, 1'b0, 5'd3, 32'h0);
        t1 = -1; t2 = -1; st2 = 0;
        for (int k = 0; k < 20 && t2 < 0; k++) begin
            @(negedge clk);
            if (k == 0) chk1("tie busy idle cycle", busy, 1'b0);
            if (k == 1) chk1("tie busy access cycle", busy, 1'b1);
            if (done_1 && t1 < 0) t1 = k;
            if (done_2) t2 = k;
            else if (stall_mem_2) st2++;
            @(posedge clk); #1;
            if (k == t1) set_core(1, 1'b0, 1'b0, 5'd0, 32'h0);
        end
        idle_pins();
        chk("tie done_1 cycle", t1, 3);
        chk("tie done_2 cycle", t2, 7);
        chk("tie stall_2 cycles", st2, 7);
        chk("tie out1", mem_data_out_1, 32'hDEADBEEF);
        chk("tie out2", mem_data_out_2, 32'hA5A5A5A5);

        // Continuous contention: grants must alternate
        pulse_reset();
        set_core(1, 1'b1, 1'b0, 5'd5, 32'h0);
        set_core(2, 1'b1, 1'b0, 5'd5, 32'h0);
        nd = 0; both = 0;
        for (int i = 0; i < 4; i++) order[i] = 0;
        for (int k = 0; k < 40 && nd < 4; k++) begin
            @(negedge clk);
            if (done_1 && done_2) both++;
            if (done_1) begin
                order[nd] = 1; nd++;
            end else if (done_2) begin
                order[nd] = 2; nd++;
            end
            @(posedge clk); #1;
        end
        idle_pins();
        chk("contention transfers", nd, 4);
        chk("contention double done", both, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("contention grant %0d", i), order[i], (i % 2 == 0) ? 1 : 2);
        end

        // Reset one cycle into ACCESS aborts the write
        set_core(1, 1'b0, 1'b1, 5'd9, 32'h00001234);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("midreset busy before", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk1("midreset busy", busy, 1'b0);
        chk1("midreset done_1", done_1, 1'b0);
        chk1("midreset stall_1 req held", stall_mem_1, 1'b1);
        chk("midreset out1", mem_data_out_1, 32'h0);
        chk("midreset out2", mem_data_out_2, 32'h0);
        @(posedge clk); #1;
        idle_pins();
        @(negedge clk);
        chk1("midreset stall_1 dropped", stall_mem_1, 1'b0);
        reset = 1'b1;
        nd1 = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_1) nd1++;
        end
        chk("midreset no done_1", nd1, 0);
        exp_out[1] = 32'h0;
        exp_out[2] = 32'h0;
        @(posedge clk); #1;
        xfer(2, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0BADF00D, "midreset readback");

        // Known memory image, then randomized traffic
        for (int a = 0; a < DEP; a++) begin
            mdl_mem[a] = 32'hC0DE0000 ^ (32'(a) * 32'h01010101);
            xfer(1, 1'b0, 1'b1, 5'(a), mdl_mem[a], 32'h0, $sformatf("init%0d", a));
        end
        pulse_reset();
        m_cur = 0; m_last = 2; m_start = 0; m_done = 0;
        m_wr = 1'b0; m_addr = 5'd0; m_data = 32'h0;
        for (int n = 1; n <= 2; n++) begin
            a_act[n] = 1'b0; a_drop[n] = 1'b0; a_rd[n] = 1'b0; a_wr[n] = 1'b0;
            a_addr[n] = 5'd0; a_data[n] = 32'h0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int n = 1; n <= 2; n++) begin
                if (a_act[n]) begin
                    // Address/data wander while waiting; only the granted-cycle value counts.
                    if ($urandom_range(0, 1) == 1) begin
                        a_addr[n] = 5'($urandom);
                        a_data[n] = $urandom;
                    end
                end else if (a_drop[n]) begin
                    a_drop[n] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    a_act[n]  = 1'b1;
                    op        = int'($urandom_range(0, 2));
                    a_rd[n]   = (op != 1);
                    a_wr[n]   = (op != 0);
                    a_addr[n] = 5'($urandom);
                    a_data[n] = $urandom;
                end
            end
            set_core(1, a_act[1] & a_rd[1], a_act[1] & a_wr[1], a_addr[1], a_data[1]);
            set_core(2, a_act[2] & a_rd[2], a_act[2] & a_wr[2], a_addr[2], a_data[2]);

            if (m_cur == 0 && (a_act[1] || a_act[2])) begin
                if (a_act[1] && a_act[2]) m_cur = (m_last == 2) ? 1 : 2;
                else m_cur = a_act[1] ? 1 : 2;
                m_start = c;
                m_done  = c + LAT + 1;
                m_wr    = a_wr[m_cur];
                m_addr  = a_addr[m_cur];
                m_data  = a_data[m_cur];
            end
            e_done[1] = (m_cur == 1) && (c == m_done);
            e_done[2] = (m_cur == 2) && (c == m_done);
            e_busy    = (m_cur != 0) && (c > m_start);
            if (m_cur != 0 && c == m_done) begin
                if (m_wr) mdl_mem[m_addr] = m_data;
                else exp_out[m_cur] = mdl_mem[m_addr];
            end

            @(negedge clk);
            chk1($sformatf("rand c%0d done_1", c), done_1, e_done[1]);
            chk1($sformatf("rand c%0d done_2", c), done_2, e_done[2]);
            chk1($sformatf("rand c%0d busy", c), busy, e_busy);
            chk1($sformatf("rand c%0d stall_1", c), stall_mem_1, a_act[1] & ~e_done[1]);
            chk1($sformatf("rand c%0d stall_2", c), stall_mem_2, a_act[2] & ~e_done[2]);
            chk($sformatf("rand c%0d out1", c), mem_data_out_1, exp_out[1]);
            chk($sformatf("rand c%0d out2", c), mem_data_out_2, exp_out[2]);

            if (m_cur != 0 && c == m_done) begin
                a_act[m_cur]  = 1'b0;
                a_drop[m_cur] = 1'b1;
                m_last        = m_cur;
                m_cur         = 0;
            end
            @(posedge clk); #1;
        end
        idle_pins();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
